data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-requester arbiter and access sequencer for the 256-word data memory. It shares the memory between the core load/store path (`core_*`) and a debug/loader port (`dbg_*`). It converts byte addresses to word indices, rejects out-of-range and misaligned accesses, and returns read data or a write acknowledge with a fixed latency. It sits between both requesters and the data memory; the memory's `RST` is tied to the same reset.

## Interface
- `DATA_W`, default 32: data width.
- `DEPTH`, default 256: memory depth in words; must be a power of 2.
- `MAX_WAIT`, default 4: number of cycles `dbg_req` may be refused before debug gets forced priority.
- `CLK`  in  1: clock. All logic is on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `core_req`  in  1: core access request; held with its fields stable until `core_gnt`.
- `core_we`  in  1: 1 = write, 0 = read.
- `core_addr`  in  32: byte address.
- `core_wdata`  in  DATA_W: write data.
- `core_gnt`  out  1: one-cycle pulse; the request has been accepted.
- `core_rvalid`  out  1: one-cycle pulse; the response is valid.
- `core_rdata`  out  DATA_W: read data, or echoed write data. Valid with `core_rvalid`.
- `core_err`  out  1: out-of-range or misaligned access. Valid with `core_rvalid`.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`, `dbg_err`: same as the core signals, for the debug port.
- `mem_addr`  out  32: word index, zero-extended, driven to the memory address input.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_we`  out  1: memory write enable.
- `mem_rdata`  in  DATA_W: memory registered read output. It is valid the cycle after the memory samples its inputs.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ISSUE: memory inputs are driven and `*_gnt` is asserted.
  - RESP: `mem_rdata` is returned to the owner and `*_rvalid` is asserted.
- Arbitration runs in IDLE and in RESP:
  - If any request is pending: capture the winner's `we`/`addr`/`wdata`, set `owner`, go to ISSUE.
  - Otherwise: go to IDLE.
- ISSUE always transitions to RESP.
- Priority:
  - Core wins by default.
  - Debug wins when `dbg_req=1` and `dbg_wait>=MAX_WAIT`.
- `dbg_wait` counter:
  - Increments, saturating at `MAX_WAIT`, on every arbitration cycle with `dbg_req=1` where core wins.
  - Clears when debug is granted.
  - Holds its value otherwise.
- Address decode:
  - word index = `addr[log2(DEPTH)+1:2]`.
  - Error if `addr[1:0]!=0` or `addr[31:log2(DEPTH)+2]!=0`.
- Error access:
  - Still passes through ISSUE and RESP.
  - `mem_we` is forced to 0 and `mem_addr` is forced to 0.
  - In RESP: `*_err=1` and `*_rdata=0`.
- Write access: RESP returns `mem_rdata`, which the memory sets to the written data, with `*_err=0`.
- Requester rule:
  - The level of `req` in the cycle after `gnt` (the RESP cycle) is taken as a new request.
  - A requester wanting a single access deasserts `req` immediately after seeing `gnt`.
- Non-owner `*_rvalid`, `*_gnt` and `*_err` are 0. Non-owner `*_rdata` is 0.

## Timing
- Reset:
  - State returns to IDLE; `owner`=core; `dbg_wait`=0.
  - All `*_gnt`, `*_rvalid`, `*_err`, `*_rdata`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - Reset applied in ISSUE or RESP aborts that access: no `rvalid`. A write in ISSUE is suppressed because `mem_we=0` on the reset edge. The memory is reset in the same cycle.
- Single access: `req` seen in IDLE at cycle N → ISSUE at N+1 (`gnt`, `mem_*` driven, memory samples at the end of N+1) → RESP at N+2 (`rvalid`).
- Back-to-back accesses: one every 2 cycles (RESP → ISSUE).
- `mem_*` outputs are driven from registered captured values only. No combinational path from `*_req`/`*_addr` to `mem_*`.
- `mem_we` is high only in ISSUE, and only for a valid write.
- Both requests arriving together in IDLE: core is granted at N+1 and debug at N+3, unless the starvation rule forces debug first.

## Structure
- Shared package `dm_arb_pkg`:
  - State enum (IDLE/ISSUE/RESP).
  - Owner encoding (`OWN_CORE=0`, `OWN_DBG=1`).
  - Function `word_idx_w(DEPTH)`.
  - Default `DEPTH`/`MAX_WAIT` constants.
- One sub-module: `dm_starve_cnt`, the saturating debug wait counter with inc/clr inputs and an `at_max` output.
- FSM, address check and response muxing stay in the top level.

## Test plan
- Core write then read:
  - Core write addr `0x10`, data `0xDEADBEEF`: `gnt` at N+1, `mem_addr=4`, `mem_we=1`; `rvalid` at N+2 with `rdata=0xDEADBEEF`.
  - Core read `0x10`: `rdata=0xDEADBEEF`, `err=0`.
- Simultaneous requests: core read `0x0` and debug read `0x4` raised together. Core `gnt` at N+1, debug `gnt` at N+3. Debug `rdata=1` (memory initial value = index).
- Starvation: core holds `req` continuously, debug requests from the same cycle with `MAX_WAIT=4`. Debug is granted at the 5th arbitration point; `dbg_wait` then reads 0.
- Errors:
  - Core write to addr `0x400`: `mem_we` stays 0; RESP has `err=1`, `rdata=0`; the read-back of word 0 is unchanged.
  - Addr `0x6` (misaligned) gives the same error response.
- Reset during ISSUE of a write to `0x20`: no `rvalid`; all outputs 0 the next cycle; word 8 holds its reset/initial value.
- Back-to-back core reads of `0x0`, `0x4`, `0x8`: `rvalid` every 2 cycles with data 0, 1, 2.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package dm_arb_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DEFAULT_DEPTH    = 256;
    localparam int unsigned DEFAULT_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

    // Decoded access captured at arbitration time.
    typedef struct packed {
        logic              we;
        logic              err;
        logic [ADDR_W-1:0] widx;
    } acc_t;

    // Number of word-index bits needed to address a memory of the given depth.
    function automatic int unsigned word_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dm_starve_cnt.sv
// Saturating counter of arbitration cycles the debug port has lost.
module dm_starve_cnt
    import dm_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Clear on debug grant, otherwise count losses up to MAX_WAIT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign at_max = (cnt_q >= CNT_W'(MAX_WAIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter and access sequencer for the data memory.
module data_mem_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned IDX_W = word_idx_w(DEPTH);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    acc_t              acc_q, acc_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              dbg_win;
    logic              cnt_inc, cnt_clr;
    logic              at_max;
    logic              in_issue, in_resp;

    // Byte address to word index plus range/alignment check.
    function automatic acc_t decode(input logic we, input logic [31:0] addr);
        acc_t a;
        a.we   = we;
        a.err  = (addr[1:0] != 2'b00) || ((addr >> (IDX_W + 2)) != 32'd0);
        a.widx = ADDR_W'(addr[IDX_W+1:2]);
        return a;
    endfunction

    dm_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .CLK    (CLK),
        .RST    (RST),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .at_max (at_max)
    );

    // State register and captured access fields.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_CORE;
            acc_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            acc_q   <= acc_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, arbitration and capture; arbitration runs in IDLE and RESP.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        acc_d   = acc_q;
        wdata_d = wdata_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        dbg_win = dbg_req && (!core_req || at_max);
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (core_req || dbg_req) begin
                    state_d = ST_ISSUE;
                    if (dbg_win) begin
                        owner_d = OWN_DBG;
                        acc_d   = decode(dbg_we, dbg_addr);
                        wdata_d = dbg_wdata;
                        cnt_clr = 1'b1;
                    end else begin
                        owner_d = OWN_CORE;
                        acc_d   = decode(core_we, core_addr);
                        wdata_d = core_wdata;
                        cnt_inc = dbg_req;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state; read data passes from the memory in RESP.
    always_comb begin
        in_issue    = (state_q == ST_ISSUE);
        in_resp     = (state_q == ST_RESP);
        core_gnt    = in_issue && (owner_q == OWN_CORE);
        dbg_gnt     = in_issue && (owner_q == OWN_DBG);
        core_rvalid = in_resp && (owner_q == OWN_CORE);
        dbg_rvalid  = in_resp && (owner_q == OWN_DBG);
        core_err    = core_rvalid && acc_q.err;
        dbg_err     = dbg_rvalid && acc_q.err;
        core_rdata  = (core_rvalid && !acc_q.err) ? mem_rdata : '0;
        dbg_rdata   = (dbg_rvalid && !acc_q.err) ? mem_rdata : '0;
        // A reset landing on ISSUE must not let the write reach the memory.
        mem_we      = in_issue && acc_q.we && !acc_q.err && !RST;
        mem_addr    = (in_issue && !acc_q.err) ? acc_q.widx : '0;
        mem_wdata   = (in_issue && !acc_q.err) ? wdata_q : '0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small memory model.
module tb_data_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic        core_gnt, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(
        .DATA_W   (32),
        .DEPTH    (256),
        .MAX_WAIT (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .dbg_err     (dbg_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    // Data memory: reset loads word i with i, write-first registered read port.
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
            mem_rdata <= '0;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata          <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated access from IDLE: gnt at N+1, response at N+2.
    task automatic single(input logic use_dbg, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        if (use_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        end
        tick();
        check({tag, "/gnt"}, use_dbg ? dbg_gnt : core_gnt, 64'd1);
        check({tag, "/mem_we"}, mem_we, (exp_err || !we) ? 64'd0 : 64'd1);
        check({tag, "/mem_addr"}, mem_addr, exp_err ? 64'd0 : 64'(addr >> 2));
        core_req = 1'b0;
        dbg_req  = 1'b0;
        tick();
        check({tag, "/rvalid"}, use_dbg ? dbg_rvalid : core_rvalid, 64'd1);
        check({tag, "/rdata"}, use_dbg ? dbg_rdata : core_rdata, 64'(exp_rdata));
        check({tag, "/err"}, use_dbg ? dbg_err : core_err, 64'(exp_err));
        tick();
    endtask

    initial begin
        RST = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
        tick();
        tick();
        check("rst/core_gnt", core_gnt, 64'd0);
        check("rst/core_rvalid", core_rvalid, 64'd0);
        check("rst/dbg_gnt", dbg_gnt, 64'd0);
        check("rst/mem_we", mem_we, 64'd0);
        check("rst/mem_addr", mem_addr, 64'd0);
        check("rst/mem_wdata", mem_wdata, 64'd0);
        check("rst/core_rdata", core_rdata, 64'd0);
        check("rst/dbg_wait", 64'(dut.u_starve.cnt_q), 64'd0);
        RST = 1'b0;
        tick();

        // Core write 0x10 then read it back.
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
        tick();
        check("wr/gnt", core_gnt, 64'd1);
        check("wr/mem_we", mem_we, 64'd1);
        check("wr/mem_addr", mem_addr, 64'd4);
        check("wr/mem_wdata", mem_wdata, 64'hDEADBEEF);
        core_req = 1'b0;
        tick();
        check("wr/rvalid", core_rvalid, 64'd1);
        check("wr/rdata", core_rdata, 64'hDEADBEEF);
        check("wr/err", core_err, 64'd0);
        tick();
        check("wr/idle_rvalid", core_rvalid, 64'd0);
        single(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "rd10");

        // Simultaneous core read 0x0 and debug read 0x4.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
        dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h4;
        tick();
        check("sim/core_gnt", core_gnt, 64'd1);
        check("sim/dbg_gnt_n1", dbg_gnt, 64'd0);
        core_req = 1'b0;
        tick();
        check("sim/core_rvalid", core_rvalid, 64'd1);
        check("sim/core_rdata", core_rdata, 64'd0);
        check("sim/dbg_rvalid_n2", dbg_rvalid, 64'd0);
        tick();
        check("sim/dbg_gnt_n3", dbg_gnt, 64'd1);
        check("sim/core_gnt_n3", core_gnt, 64'd0);
        check("sim/mem_addr", mem_addr, 64'd1);
        dbg_req = 1'b0;
        tick();
        check("sim/dbg_rvalid", dbg_rvalid, 64'd1);
        check("sim/dbg_rdata", dbg_rdata, 64'd1);
        check("sim/core_rdata_nonowner", core_rdata, 64'd0);
        tick();

        // Starvation: core holds req; debug wins at the 5th arbitration point.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
        dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'hC;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("starve/core_gnt%0d", k), core_gnt, 64'd1);
            check($sformatf("starve/dbg_gnt%0d", k), dbg_gnt, 64'd0);
            check($sformatf("starve/wait%0d", k), 64'(dut.u_starve.cnt_q), 64'(k));
            tick();
            check($sformatf("starve/core_rvalid%0d", k), core_rvalid, 64'd1);
        end
        tick();
        check("starve/dbg_gnt", dbg_gnt, 64'd1);
        check("starve/core_gnt_lost", core_gnt, 64'd0);
        check("starve/wait_clr", 64'(dut.u_starve.cnt_q), 64'd0);
        dbg_req = 1'b0;
        tick();
        check("starve/dbg_rvalid", dbg_rvalid, 64'd1);
        check("starve/dbg_rdata", dbg_rdata, 64'd3);
        tick();
        check("starve/core_regain", core_gnt, 64'd1);
        core_req = 1'b0;
        tick();
        check("starve/core_last_rvalid", core_rvalid, 64'd1);
        tick();

        // Error accesses: out of range and misaligned.
        single(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1, "err400");
        single(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "rd0_after_err");
        single(1'b0, 1'b1, 32'h6, 32'h12345678, 32'h0, 1'b1, "err_mis");
        single(1'b1, 1'b0, 32'h8, 32'h0, 32'h2, 1'b0, "dbg_rd8");

        // Back-to-back core reads 0x0, 0x4, 0x8.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("b2b/gnt%0d", k), core_gnt, 64'd1);
            if (k < 2) core_addr = 32'(4 * (k + 1));
            else core_req = 1'b0;
            tick();
            check($sformatf("b2b/rvalid%0d", k), core_rvalid, 64'd1);
            check($sformatf("b2b/rdata%0d", k), core_rdata, 64'(k));
        end
        tick();
        check("b2b/idle", core_rvalid, 64'd0);

        // Reset during ISSUE of a write to 0x20.
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'hA5A5A5A5;
        tick();
        check("rstiss/gnt", core_gnt, 64'd1);
        RST = 1'b1;
        core_req = 1'b0;
        #1;
        check("rstiss/mem_we_on_reset", mem_we, 64'd0);
        tick();
        check("rstiss/rvalid", core_rvalid, 64'd0);
        check("rstiss/gnt_after", core_gnt, 64'd0);
        check("rstiss/mem_addr", mem_addr, 64'd0);
        check("rstiss/mem_wdata", mem_wdata, 64'd0);
        RST = 1'b0;
        tick();
        check("rstiss/no_rvalid", core_rvalid, 64'd0);
        single(1'b0, 1'b0, 32'h20, 32'h0, 32'h8, 1'b0, "rd20");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
